// File: rtl/m_axi_lite_cmd_master.sv
// AXI4-Lite master: one valid/ready command in, one AXI4-Lite single-beat transaction out,
// one valid/ready response back. Includes a per-transaction timeout for hung slaves.
module m_axi_lite_cmd_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_areset,
  // Command port
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_wr,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  // Response port
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  // AW channel
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // W channel
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // B channel
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AR channel
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // R channel
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int unsigned StrbW = DATA_W / 8;
  // Keep at least one counter bit so TIMEOUT=0 (disabled) still elaborates cleanly.
  localparam int unsigned CntW  = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrResp,
    StRdReq,
    StRdData,
    StResp
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic                cmd_ready_q, cmd_ready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [StrbW-1:0]    wstrb_q, wstrb_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;
  logic                rsp_timeout_q, rsp_timeout_d;

  logic                timeout_hit;
  logic                abort;
  logic                aw_done, w_done;

  assign cnt_inc     = cnt_q + CntW'(1);
  // Fires in the cycle whose increment brings the count to TIMEOUT.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CntW'(TIMEOUT));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;
    aw_done       = 1'b0;
    w_done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          cnt_d = '0;
          if (cmd_wr) begin
            state_d   = StWrReq;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = StRdReq;
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      StWrReq: begin
        cnt_d   = cnt_inc;
        // A channel counts as done if it already handshook or handshakes now.
        aw_done = !awvalid_q || m_axi_awready;
        w_done  = !wvalid_q || m_axi_wready;
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d  = StWrResp;
          bready_d = 1'b1;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      StWrResp: begin
        cnt_d = cnt_inc;
        if (m_axi_bvalid) begin
          state_d       = StResp;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi_bresp;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      StRdReq: begin
        cnt_d = cnt_inc;
        if (m_axi_arready) begin
          state_d   = StRdData;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      StRdData: begin
        cnt_d = cnt_inc;
        if (m_axi_rvalid) begin
          state_d       = StResp;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_resp_d    = m_axi_rresp;
          rsp_rdata_d   = m_axi_rdata;
          rsp_timeout_d = 1'b0;
        end else if (timeout_hit) begin
          abort = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abandon the hung transaction: every AXI valid/ready drops next cycle.
    if (abort) begin
      state_d       = StResp;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_rdata_d   = '0;
      rsp_timeout_d = 1'b1;
    end

    cmd_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge m_axi_aclk or posedge m_axi_areset) begin
    if (m_axi_areset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_m_axi_lite_cmd_master.sv
// Directed bench for m_axi_lite_cmd_master: a 32-bit instance (TIMEOUT=8) driven by hand,
// and a 16/64-bit instance against a small always-ready memory slave.
module tb_m_axi_lite_cmd_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: ADDR_W=32, DATA_W=32, TIMEOUT=8
  logic        a_cmd_valid, a_cmd_ready, a_cmd_wr;
  logic [31:0] a_cmd_addr, a_cmd_wdata;
  logic [3:0]  a_cmd_strb;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_timeout;
  logic [31:0] a_rsp_rdata;
  logic [1:0]  a_rsp_resp;
  logic [31:0] a_awaddr, a_wdata, a_araddr, a_rdata;
  logic [2:0]  a_awprot, a_arprot;
  logic [3:0]  a_wstrb;
  logic        a_awvalid, a_awready, a_wvalid, a_wready, a_bvalid, a_bready;
  logic        a_arvalid, a_arready, a_rvalid, a_rready;
  logic [1:0]  a_bresp, a_rresp;

  // Instance B: ADDR_W=16, DATA_W=64, default TIMEOUT
  logic        b_cmd_valid, b_cmd_ready, b_cmd_wr;
  logic [15:0] b_cmd_addr;
  logic [63:0] b_cmd_wdata;
  logic [7:0]  b_cmd_strb;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_timeout;
  logic [63:0] b_rsp_rdata;
  logic [1:0]  b_rsp_resp;
  logic [15:0] b_awaddr, b_araddr;
  logic [63:0] b_wdata, b_rdata;
  logic [2:0]  b_awprot, b_arprot;
  logic [7:0]  b_wstrb;
  logic        b_awvalid, b_awready, b_wvalid, b_wready, b_bvalid, b_bready;
  logic        b_arvalid, b_arready, b_rvalid, b_rready;
  logic [1:0]  b_bresp, b_rresp;

  m_axi_lite_cmd_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8)) dut_a (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_wr(a_cmd_wr),
    .cmd_addr(a_cmd_addr), .cmd_wdata(a_cmd_wdata), .cmd_strb(a_cmd_strb),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_resp(a_rsp_resp), .rsp_timeout(a_rsp_timeout),
    .m_axi_awaddr(a_awaddr), .m_axi_awprot(a_awprot), .m_axi_awvalid(a_awvalid),
    .m_axi_awready(a_awready),
    .m_axi_wdata(a_wdata), .m_axi_wstrb(a_wstrb), .m_axi_wvalid(a_wvalid),
    .m_axi_wready(a_wready),
    .m_axi_bresp(a_bresp), .m_axi_bvalid(a_bvalid), .m_axi_bready(a_bready),
    .m_axi_araddr(a_araddr), .m_axi_arprot(a_arprot), .m_axi_arvalid(a_arvalid),
    .m_axi_arready(a_arready),
    .m_axi_rdata(a_rdata), .m_axi_rresp(a_rresp), .m_axi_rvalid(a_rvalid),
    .m_axi_rready(a_rready)
  );

  m_axi_lite_cmd_master #(.ADDR_W(16), .DATA_W(64)) dut_b (
    .m_axi_aclk(clk), .m_axi_areset(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_wr(b_cmd_wr),
    .cmd_addr(b_cmd_addr), .cmd_wdata(b_cmd_wdata), .cmd_strb(b_cmd_strb),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_resp(b_rsp_resp), .rsp_timeout(b_rsp_timeout),
    .m_axi_awaddr(b_awaddr), .m_axi_awprot(b_awprot), .m_axi_awvalid(b_awvalid),
    .m_axi_awready(b_awready),
    .m_axi_wdata(b_wdata), .m_axi_wstrb(b_wstrb), .m_axi_wvalid(b_wvalid),
    .m_axi_wready(b_wready),
    .m_axi_bresp(b_bresp), .m_axi_bvalid(b_bvalid), .m_axi_bready(b_bready),
    .m_axi_araddr(b_araddr), .m_axi_arprot(b_arprot), .m_axi_arvalid(b_arvalid),
    .m_axi_arready(b_arready),
    .m_axi_rdata(b_rdata), .m_axi_rresp(b_rresp), .m_axi_rvalid(b_rvalid),
    .m_axi_rready(b_rready)
  );

  // B-channel handshakes seen on instance A.
  int a_bhs = 0;
  always @(posedge clk) if (a_bvalid && a_bready) a_bhs <= a_bhs + 1;

  // Memory slave for instance B: always-ready AW/W/AR, B/R one cycle later.
  logic [63:0] mem [0:31];

  function automatic logic [63:0] strb_mask(input logic [7:0] s);
    logic [63:0] m;
    for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{s[j]}};
    return m;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      b_bvalid <= 1'b0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
      for (int j = 0; j < 32; j++) mem[j] <= '0;
    end else begin
      if (b_awvalid && b_wvalid) begin
        mem[b_awaddr[4:0]] <= (mem[b_awaddr[4:0]] & ~strb_mask(b_wstrb)) |
                              (b_wdata & strb_mask(b_wstrb));
        b_bvalid <= 1'b1;
      end else if (b_bvalid && b_bready) begin
        b_bvalid <= 1'b0;
      end
      if (b_arvalid) begin
        b_rdata  <= mem[b_araddr[4:0]];
        b_rvalid <= 1'b1;
      end else if (b_rvalid && b_rready) begin
        b_rvalid <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       input logic [3:0] strb);
    a_cmd_valid = 1'b1;
    a_cmd_wr    = wr;
    a_cmd_addr  = addr;
    a_cmd_wdata = data;
    a_cmd_strb  = strb;
  endtask

  // One instance-B transaction with bounded waits; checks response against exp_rdata.
  task automatic b_txn(input logic wr, input logic [15:0] addr, input logic [63:0] data,
                       input logic [63:0] exp_rdata, input string tag);
    b_cmd_valid = 1'b1;
    b_cmd_wr    = wr;
    b_cmd_addr  = addr;
    b_cmd_wdata = data;
    b_cmd_strb  = 8'hFF;
    for (int k = 0; k < 20 && !b_cmd_ready; k++) tick();
    chk({tag, "_cmd_ready"}, 64'(b_cmd_ready), 64'd1);
    tick();
    b_cmd_valid = 1'b0;
    for (int k = 0; k < 20 && !b_rsp_valid; k++) tick();
    chk({tag, "_rsp_valid"}, 64'(b_rsp_valid), 64'd1);
    chk({tag, "_resp"}, 64'(b_rsp_resp), 64'd0);
    chk({tag, "_rdata"}, b_rsp_rdata, exp_rdata);
    tick();
  endtask

  initial begin
    a_cmd_valid = 0; a_cmd_wr = 0; a_cmd_addr = 0; a_cmd_wdata = 0; a_cmd_strb = 0;
    a_rsp_ready = 0; a_awready = 0; a_wready = 0; a_bvalid = 0; a_bresp = 0;
    a_arready = 0; a_rvalid = 0; a_rdata = 0; a_rresp = 0;
    b_cmd_valid = 0; b_cmd_wr = 0; b_cmd_addr = 0; b_cmd_wdata = 0; b_cmd_strb = 0;
    b_rsp_ready = 1; b_awready = 1; b_wready = 1; b_arready = 1; b_bresp = 0; b_rresp = 0;
    rst = 0;
    #2 rst = 1;

    // Reset state
    repeat (2) tick();
    chk("rst_cmd_ready", 64'(a_cmd_ready), 64'd0);
    chk("rst_awvalid", 64'(a_awvalid), 64'd0);
    chk("rst_rsp_valid", 64'(a_rsp_valid), 64'd0);
    chk("rst_awaddr", 64'(a_awaddr), 64'd0);
    rst = 0;
    chk("rel_cmd_ready0", 64'(a_cmd_ready), 64'd0);
    tick();
    chk("rel_cmd_ready1", 64'(a_cmd_ready), 64'd1);

    // Write with an always-ready slave: response 3 cycles after acceptance
    a_awready = 1; a_wready = 1; a_bvalid = 1; a_bresp = 2'b00; a_rsp_ready = 1;
    a_cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111);
    tick();
    a_cmd_valid = 0;
    chk("w1_awvalid", 64'(a_awvalid), 64'd1);
    chk("w1_wvalid", 64'(a_wvalid), 64'd1);
    chk("w1_awaddr", 64'(a_awaddr), 64'h10);
    chk("w1_wdata", 64'(a_wdata), 64'hDEAD_BEEF);
    chk("w1_wstrb", 64'(a_wstrb), 64'hF);
    chk("w1_awprot", 64'(a_awprot), 64'd0);
    chk("w1_cmd_ready", 64'(a_cmd_ready), 64'd0);
    tick();
    chk("w1_valids_low", 64'({a_awvalid, a_wvalid}), 64'd0);
    chk("w1_bready", 64'(a_bready), 64'd1);
    chk("w1_no_rsp_yet", 64'(a_rsp_valid), 64'd0);
    tick();
    chk("w1_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("w1_rsp", 64'({a_rsp_resp, a_rsp_timeout}), 64'd0);
    chk("w1_rsp_rdata", 64'(a_rsp_rdata), 64'd0);
    chk("w1_bready_low", 64'(a_bready), 64'd0);
    tick();
    a_bvalid = 0;
    chk("w1_rsp_done", 64'(a_rsp_valid), 64'd0);
    chk("w1_cmd_ready_back", 64'(a_cmd_ready), 64'd1);

    // Write with wready arriving 5 cycles after awready
    a_wready = 0;
    a_cmd(1'b1, 32'h0000_0020, 32'h1234_5678, 4'b0101);
    tick();
    a_cmd_valid = 0;
    chk("w2_wstrb", 64'(a_wstrb), 64'h5);
    chk("w2_both_valid", 64'({a_awvalid, a_wvalid}), 64'b11);
    tick();
    chk("w2_aw_done_w_held", 64'({a_awvalid, a_wvalid}), 64'b01);
    repeat (4) tick();
    chk("w2_w_still_held", 64'({a_awvalid, a_wvalid, a_bready}), 64'b010);
    a_wready = 1;
    tick();
    a_wready = 0; a_bvalid = 1;
    chk("w2_w_done", 64'({a_wvalid, a_bready}), 64'b01);
    tick();
    a_bvalid = 0;
    chk("w2_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("w2_bready_low", 64'(a_bready), 64'd0);
    tick();
    chk("w2_rsp_done", 64'(a_rsp_valid), 64'd0);
    chk("w2_one_b", 64'(a_bhs), 64'd2);

    // Read with SLVERR and response back-pressure
    a_rsp_ready = 0; a_arready = 1; a_rvalid = 1; a_rdata = 32'h0000_00A5; a_rresp = 2'b10;
    a_cmd(1'b0, 32'h0000_0014, 32'h0, 4'h0);
    tick();
    a_cmd_valid = 0;
    chk("r1_arvalid", 64'(a_arvalid), 64'd1);
    chk("r1_araddr", 64'(a_araddr), 64'h14);
    chk("r1_arprot", 64'(a_arprot), 64'd0);
    tick();
    chk("r1_ar_done", 64'({a_arvalid, a_rready}), 64'b01);
    tick();
    a_rvalid = 0; a_arready = 0;
    chk("r1_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("r1_rdata", 64'(a_rsp_rdata), 64'hA5);
    chk("r1_resp", 64'({a_rsp_resp, a_rsp_timeout}), 64'b100);
    chk("r1_rready_low", 64'(a_rready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("r1_hold", 64'({a_rsp_valid, a_rsp_resp, a_rsp_rdata}), {31'd0, 1'b1, 2'b10, 32'hA5});
    end
    a_rsp_ready = 1;
    tick();
    chk("r1_rsp_done", 64'(a_rsp_valid), 64'd0);
    chk("r1_cmd_ready", 64'(a_cmd_ready), 64'd1);

    // Timeout: arready never rises, arvalid stays up exactly 8 cycles
    a_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0);
    tick();
    a_cmd_valid = 0;
    chk("to_arvalid_c1", 64'(a_arvalid), 64'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("to_arvalid_c8", 64'({a_arvalid, a_rsp_valid}), 64'b10);
    tick();
    chk("to_arvalid_low", 64'(a_arvalid), 64'd0);
    chk("to_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("to_rsp", 64'({a_rsp_resp, a_rsp_timeout}), 64'b101);
    chk("to_rdata", 64'(a_rsp_rdata), 64'd0);
    tick();
    chk("to_rsp_done", 64'(a_rsp_valid), 64'd0);

    // Asynchronous reset during WR_RESP
    a_awready = 1; a_wready = 1;
    a_cmd(1'b1, 32'h0000_0030, 32'h5555_AAAA, 4'hF);
    tick();
    a_cmd_valid = 0;
    tick();
    chk("rw_bready", 64'(a_bready), 64'd1);
    #1 rst = 1;
    #1;
    chk("rw_async_drop",
        64'({a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready, a_rsp_valid, a_cmd_ready}),
        64'd0);
    chk("rw_awaddr_clr", 64'(a_awaddr), 64'd0);
    @(posedge clk);
    #1 rst = 0;
    tick();
    chk("rw_cmd_ready", 64'(a_cmd_ready), 64'd1);
    chk("rw_no_rsp", 64'(a_rsp_valid), 64'd0);
    a_bvalid = 1;
    a_cmd(1'b1, 32'h0000_0044, 32'hCAFE_F00D, 4'hF);
    tick();
    a_cmd_valid = 0;
    tick();
    tick();
    chk("rw2_rsp_valid", 64'(a_rsp_valid), 64'd1);
    chk("rw2_rsp", 64'({a_rsp_resp, a_rsp_timeout}), 64'd0);
    tick();
    a_bvalid = 0;
    chk("rw2_rsp_done", 64'(a_rsp_valid), 64'd0);
    chk("a_b_count", 64'(a_bhs), 64'd3);

    // 64-bit instance: write/read pairs against the memory slave
    for (int i = 0; i < 10; i++) begin
      logic [15:0] addr;
      addr = 16'($urandom_range(0, 20));
      b_txn(1'b1, addr, 64'(i + 1), 64'd0, "b_wr");
      b_txn(1'b0, addr, 64'd0, 64'(i + 1), "b_rd");
    end
    chk("b_timeout_flag", 64'(b_rsp_timeout), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no completion expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
